// File: rtl/scan_display_ctrl_pkg.sv
// rtl/scan_display_ctrl_pkg.sv - shared state encoding, codes and width helper for the scan controller
package scan_display_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Never returns less than 1 so the result is always usable as a vector width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/scan_display_ctrl_if.sv
// rtl/scan_display_ctrl_if.sv - host write port and decoder-side display bus of the scan controller
interface scan_display_ctrl_if
  import scan_display_ctrl_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int AW   = clog2(NDIG)
);
  logic            run_i;
  logic            lzs_i;
  logic            we_i;
  logic [AW-1:0]   waddr_i;
  logic [3:0]      wdata_i;
  logic            en_o;
  logic [3:0]      a_o;
  logic [NDIG-1:0] dig_sel_o;
  logic            frame_o;

  modport master (
    output run_i, lzs_i, we_i, waddr_i, wdata_i,
    input  en_o, a_o, dig_sel_o, frame_o
  );

  modport slave (
    input  run_i, lzs_i, we_i, waddr_i, wdata_i,
    output en_o, a_o, dig_sel_o, frame_o
  );
endinterface

// File: rtl/scan_display_ctrl_lz_mask.sv
// rtl/scan_display_ctrl_lz_mask.sv - leading-zero suppress mask, OR chain running down from the MSD
module scan_display_ctrl_lz_mask #(
  parameter int NDIG = 8
) (
  input  logic [NDIG-1:1][3:0] digit_i,
  input  logic                 lzs_i,
  output logic [NDIG-1:0]      mask_o
);

  // nz[i]: some digit at or above position i is non-zero. Digit 0 is never
  // suppressed, so its value is not needed here.
  logic [NDIG:1] nz;

  assign nz[NDIG]  = 1'b0;
  assign mask_o[0] = 1'b0;

  for (genvar i = NDIG - 1; i >= 1; i--) begin : g_chain
    assign nz[i]     = (digit_i[i] != 4'd0) | nz[i+1];
    assign mask_o[i] = lzs_i & ~nz[i];
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - time-multiplexed 7-segment scan controller with blanking and zero suppression
module scan_display_ctrl
  import scan_display_ctrl_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 50,
  parameter int AW        = clog2(NDIG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  scan_display_ctrl_if.slave bus
);

  localparam int IW = clog2(NDIG);
  localparam int CW = clog2((SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NDIG-1:0][3:0] digit_q;
  logic [NDIG-1:0]     supp;
  logic                wr_ok;

  logic                en_q, en_d;
  logic [3:0]          a_q, a_d;
  logic [NDIG-1:0]     sel_q, sel_d;
  logic                frame_q, frame_d;

  assign wr_ok = bus.we_i && (32'(bus.waddr_i) < NDIG);

  scan_display_ctrl_lz_mask #(.NDIG(NDIG)) u_lz_mask (
    .digit_i (digit_q[NDIG-1:1]),
    .lzs_i   (bus.lzs_i),
    .mask_o  (supp)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      en_q    <= 1'b0;
      a_q     <= '0;
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      if (wr_ok) digit_q[bus.waddr_i[IW-1:0]] <= bus.wdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.run_i) state_d = BLANK;
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping RUN aborts the scan from any state; the next start is at digit 0.
    if (!bus.run_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    en_d    = 1'b0;
    a_d     = '0;
    sel_d   = '0;
    frame_d = 1'b0;
    if (state_d == SHOW) begin
      sel_d   = {{(NDIG-1){1'b0}}, 1'b1} << idx_d;
      a_d     = digit_q[idx_d];
      en_d    = ~supp[idx_d];
      frame_d = (state_q != SHOW) && (idx_d == '0);
    end
  end

  assign bus.en_o      = en_q;
  assign bus.a_o       = a_q;
  assign bus.dig_sel_o = sel_q;
  assign bus.frame_o   = frame_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb/tb_scan_display_ctrl.sv - randomized self-checking bench for scan_display_ctrl
module tb_scan_display_ctrl;
  localparam int NDIG      = 4;
  localparam int SHOW_CYC  = 4;
  localparam int BLANK_CYC = 2;
  localparam int AW        = 3;
  localparam int SLOT      = BLANK_CYC + SHOW_CYC;
  localparam int FRAME_LEN = NDIG * SLOT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  scan_display_ctrl_if #(.NDIG(NDIG), .AW(AW)) bus ();

  scan_display_ctrl #(
    .NDIG(NDIG), .SHOW_CYC(SHOW_CYC), .BLANK_CYC(BLANK_CYC), .AW(AW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: m_t is the position inside the frame (-1 = dark/idle); digit,
  // blank/show phase and suppression follow from plain arithmetic on it.
  int              m_t = -1;
  int              m_dig [NDIG];
  logic            exp_en = 1'b0;
  logic [3:0]      exp_a = 4'd0;
  logic [NDIG-1:0] exp_sel = '0;
  logic            exp_frame = 1'b0;
  int              md, mph;
  bit              mallz;

  always @(posedge clk) begin
    if (rst) begin
      m_t = -1;
      foreach (m_dig[i]) m_dig[i] = 0;
      exp_en = 1'b0; exp_a = 4'd0; exp_sel = '0; exp_frame = 1'b0;
    end else begin
      if (!bus.run_i) m_t = -1;
      else            m_t = (m_t < 0) ? 0 : (m_t + 1) % FRAME_LEN;
      exp_en = 1'b0; exp_a = 4'd0; exp_sel = '0; exp_frame = 1'b0;
      if (m_t >= 0) begin
        md  = m_t / SLOT;
        mph = m_t % SLOT;
        if (mph >= BLANK_CYC) begin
          mallz = 1'b1;
          for (int j = md; j < NDIG; j++) if (m_dig[j] != 0) mallz = 1'b0;
          exp_sel   = NDIG'(1) << md;
          exp_a     = 4'(m_dig[md]);
          exp_en    = !(bus.lzs_i && md != 0 && mallz);
          exp_frame = (md == 0 && mph == BLANK_CYC);
        end
      end
      if (bus.we_i && int'(bus.waddr_i) < NDIG) m_dig[int'(bus.waddr_i)] = int'(bus.wdata_i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run_i = 1'b0; bus.lzs_i = 1'b0; bus.we_i = 1'b0;
    bus.waddr_i = '0; bus.wdata_i = '0;
    repeat (3) tick();
    checks++;
    if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== '0)
      begin failures++; $display("FAIL reset_outputs got en=%b a=%h sel=%b frame=%b want all zero", bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o); end
    for (int i = 0; i < NDIG; i++) begin
      checks++;
      if (dut.digit_q[i] !== 4'd0)
        begin failures++; $display("FAIL reset_digit%0d got %h want 0", i, dut.digit_q[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int last_f = -1;
    int nframes = 0;
    for (int i = 0; i < NDIG; i++) begin
      bus.we_i = 1'b1; bus.waddr_i = AW'(i); bus.wdata_i = 4'(4 - i);
      tick();
      checks++;
      if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== {exp_en, exp_a, exp_sel, exp_frame})
        begin failures++; $display("FAIL idle_write got en=%b a=%h sel=%b fr=%b want en=%b a=%h sel=%b fr=%b", bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o, exp_en, exp_a, exp_sel, exp_frame); end
    end
    bus.we_i = 1'b0;
    bus.run_i = 1'b1;
    for (int c = 0; c < 2 * FRAME_LEN; c++) begin
      tick();
      checks++;
      if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== {exp_en, exp_a, exp_sel, exp_frame})
        begin failures++; $display("FAIL scan c=%0d got en=%b a=%h sel=%b fr=%b want en=%b a=%h sel=%b fr=%b", c, bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o, exp_en, exp_a, exp_sel, exp_frame); end
      if (bus.frame_o === 1'b1) begin
        nframes++;
        if (last_f >= 0) begin
          checks++;
          if (c - last_f !== FRAME_LEN)
            begin failures++; $display("FAIL frame_period got %0d want %0d", c - last_f, FRAME_LEN); end
        end
        last_f = c;
      end
    end
    checks++;
    if (nframes !== 2)
      begin failures++; $display("FAIL frame_count got %0d want 2", nframes); end
  endtask

  task automatic test_lzs();
    int bad_lit = 0;
    bus.lzs_i = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NDIG; i++) begin
        bus.we_i = 1'b1; bus.waddr_i = AW'(i);
        bus.wdata_i = (s == 0 && i == 1) ? 4'd5 : 4'd0;
        tick();
      end
      bus.we_i = 1'b0;
      for (int c = 0; c < FRAME_LEN + 4; c++) begin
        tick();
        checks++;
        if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== {exp_en, exp_a, exp_sel, exp_frame})
          begin failures++; $display("FAIL lzs s=%0d c=%0d got en=%b a=%h sel=%b want en=%b a=%h sel=%b", s, c, bus.en_o, bus.a_o, bus.dig_sel_o, exp_en, exp_a, exp_sel); end
        if (s == 1 && bus.en_o === 1'b1 && bus.dig_sel_o !== 4'b0001) bad_lit++;
      end
    end
    checks++;
    if (bad_lit !== 0)
      begin failures++; $display("FAIL lzs_all_zero lit_non_lsd got %0d want 0", bad_lit); end
  endtask

  task automatic test_write_show();
    int k;
    for (k = 0; k < 2 * FRAME_LEN && m_t != 2 * SLOT + BLANK_CYC + 1; k++) begin
      tick();
      checks++;
      if ({bus.en_o, bus.a_o, bus.dig_sel_o} !== {exp_en, exp_a, exp_sel})
        begin failures++; $display("FAIL ws_wait got en=%b a=%h sel=%b want en=%b a=%h sel=%b", bus.en_o, bus.a_o, bus.dig_sel_o, exp_en, exp_a, exp_sel); end
    end
    checks++;
    if (m_t != 2 * SLOT + BLANK_CYC + 1)
      begin failures++; $display("FAIL ws_reach_digit2 got t=%0d want %0d", m_t, 2 * SLOT + BLANK_CYC + 1); end
    bus.we_i = 1'b1; bus.waddr_i = 3'd2; bus.wdata_i = 4'd9;
    for (int c = 0; c < 12; c++) begin
      tick();
      bus.we_i = 1'b0;
      checks++;
      if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== {exp_en, exp_a, exp_sel, exp_frame})
        begin failures++; $display("FAIL write_show c=%0d got en=%b a=%h sel=%b want en=%b a=%h sel=%b", c, bus.en_o, bus.a_o, bus.dig_sel_o, exp_en, exp_a, exp_sel); end
      if (m_t == 2 * SLOT + BLANK_CYC + 3) begin
        checks++;
        if ({bus.en_o, bus.a_o, bus.dig_sel_o} !== {1'b1, 4'd9, 4'b0100})
          begin failures++; $display("FAIL write_show_4th got en=%b a=%h sel=%b want en=1 a=9 sel=0100", bus.en_o, bus.a_o, bus.dig_sel_o); end
      end
    end
  endtask

  task automatic test_run_drop();
    int k;
    int frame_at = -1;
    for (k = 0; k < 2 * FRAME_LEN && m_t != SLOT + BLANK_CYC + 2; k++) tick();
    checks++;
    if (m_t != SLOT + BLANK_CYC + 2)
      begin failures++; $display("FAIL rd_reach_digit1 got t=%0d want %0d", m_t, SLOT + BLANK_CYC + 2); end
    bus.run_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 2) bus.run_i = 1'b1;
      checks++;
      if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== {exp_en, exp_a, exp_sel, exp_frame})
        begin failures++; $display("FAIL run_drop c=%0d got en=%b sel=%b fr=%b want en=%b sel=%b fr=%b", c, bus.en_o, bus.dig_sel_o, bus.frame_o, exp_en, exp_sel, exp_frame); end
      if (bus.frame_o === 1'b1 && frame_at < 0) frame_at = c;
    end
    checks++;
    if (frame_at !== 2 + 1 + BLANK_CYC)
      begin failures++; $display("FAIL restart_frame got cycle %0d want %0d", frame_at, 3 + BLANK_CYC); end
  endtask

  task automatic test_rst_mid();
    int k;
    for (k = 0; k < 2 * FRAME_LEN && m_t != 2 * SLOT + BLANK_CYC + 1; k++) tick();
    rst = 1'b1; bus.we_i = 1'b1; bus.waddr_i = 3'd2; bus.wdata_i = 4'd7;
    tick();
    rst = 1'b0; bus.we_i = 1'b0;
    checks++;
    if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== '0)
      begin failures++; $display("FAIL rst_mid_outputs got en=%b a=%h sel=%b fr=%b want all zero", bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o); end
    for (int i = 0; i < NDIG; i++) begin
      checks++;
      if (dut.digit_q[i] !== 4'd0)
        begin failures++; $display("FAIL rst_mid_digit%0d got %h want 0", i, dut.digit_q[i]); end
    end
  endtask

  task automatic test_oob();
    for (int i = 0; i < 2 * NDIG; i++) begin
      bus.we_i = 1'b1; bus.waddr_i = AW'(i);
      bus.wdata_i = (i < NDIG) ? 4'(6 + i) : 4'hA;
      tick();
    end
    bus.we_i = 1'b0;
    tick();
    for (int i = 0; i < NDIG; i++) begin
      checks++;
      if (dut.digit_q[i] !== 4'(6 + i) || dut.digit_q[i] !== 4'(m_dig[i]))
        begin failures++; $display("FAIL oob_digit%0d got %h want %h", i, dut.digit_q[i], 4'(6 + i)); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) bus.lzs_i = ~bus.lzs_i;
      if ($urandom_range(0, 49) == 0) bus.run_i = ~bus.run_i;
      else if ($urandom_range(0, 9) == 0) bus.run_i = 1'b1;
      bus.we_i    = ($urandom_range(0, 2) == 0);
      bus.waddr_i = AW'($urandom_range(0, 7));
      bus.wdata_i = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      tick();
      checks++;
      if ({bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o} !== {exp_en, exp_a, exp_sel, exp_frame})
        begin failures++; $display("FAIL random c=%0d got en=%b a=%h sel=%b fr=%b want en=%b a=%h sel=%b fr=%b", c, bus.en_o, bus.a_o, bus.dig_sel_o, bus.frame_o, exp_en, exp_a, exp_sel, exp_frame); end
      for (int i = 0; i < NDIG; i++) begin
        checks++;
        if (dut.digit_q[i] !== 4'(m_dig[i]))
          begin failures++; $display("FAIL random_digit%0d c=%0d got %h want %h", i, c, dut.digit_q[i], 4'(m_dig[i])); end
      end
    end
    rst = 1'b0; bus.we_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzs();
    test_write_show();
    test_run_drop();
    test_rst_mid();
    test_oob();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
